ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded RS/RT operands of the instruction currently in EX and owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with a fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Raises Busy so hazard logic can stall dependent mfhi/mflo/md instructions in ID.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (legal range 1..15).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- A  in  32  RS operand, forwarded value in EX.
- B  in  32  RT operand, forwarded value in EX.
- Op  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- Start  in  1  the instruction in EX is a valid md instruction this cycle.
- Flush  in  1  an exception or interrupt is being taken this cycle; suppresses Start.
- Busy  out  1  an operation is in progress.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset: on any edge with Reset=1, Busy=0, HI=0, LO=0, cycle counter=0, and any pending result is discarded. This applies mid-operation as well.

Accept condition:
- Start=1 and Flush=0 and Busy=0 at a rising edge.
- If the condition is false, the unit takes no action.
- Start while Busy=1 is ignored; hazard logic guarantees this does not occur.

mult/multu (Op 1/2):
- Full 64-bit product (signed or unsigned) is computed from A and B at the accept edge and held in an internal {hi,lo} result register.
- Counter loads MULT_CYCLES and Busy=1 from the next cycle.

div/divu (Op 3/4):
- Quotient goes to LO, remainder to HI. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Counter loads DIV_CYCLES.
- B=0: Busy timing is identical, but HI/LO are NOT updated at completion.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

Timing:
- Busy is high for exactly N cycles after the accept edge, then drops.
- HI/LO take the result on the same edge that clears Busy, so the new value is visible in the first cycle with Busy=0.
- Counter decrements once per cycle while Busy=1.

mthi/mtlo (Op 5/6):
- On an accepted edge, HI<=A or LO<=A respectively.
- Busy stays 0; no latency.

Flush:
- Flush only blocks acceptance.
- An operation already Busy runs to completion and commits, because its instruction has already retired past EX.

Outputs:
- Busy, HI and LO are all registered; no combinational path from the inputs.
- HI/LO hold their value whenever no commit is occurring.

FSM:
- IDLE -> BUSY on accept of Op 1..4.
- BUSY -> BUSY while counter>1.
- BUSY -> IDLE when counter==1, committing the result.
- Reset -> IDLE from any state.
- Ops 5/6 stay in IDLE.

Test Plan:
- mult, A=0xFFFFFFFF, B=2, Start one cycle -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands -> after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu, A=7, B=0 -> Busy for 10 cycles, HI/LO unchanged.
- mthi, A=0x12345678 with Busy=0 -> HI=0x12345678 on the next edge, Busy stays 0. Start mthi while a mult is Busy -> ignored, and the mult result commits.
- Start=1, Flush=1, Op=mult -> Busy stays 0 and HI/LO unchanged. Flush raised during cycle 3 of a Busy mult -> the mult still commits after cycle 5.
- Reset asserted during Busy cycle 3 of a div -> the next cycle has Busy=0, HI=0, LO=0, and no later commit occurs.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div over a fixed
// number of Busy cycles and commits the result on the edge that clears Busy.
module ex_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic { S_IDLE, S_BUSY } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] res_p1;      // {hi, lo} held until commit
    logic        res_vld_p1;  // cleared for divide-by-zero so HI/LO are untouched
    logic        accept;

    // Operands are widened according to signedness, so the low 64 bits of the
    // product are correct for both mult and multu.
    function automatic logic signed [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                                 input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction

    // Magnitude divide then re-sign: truncates toward zero, remainder follows
    // the dividend, and 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    function automatic logic [63:0] div_qr(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic [31:0] ua, ub, uq, ur;
        logic        neg_q, neg_r;
        neg_r = sgn & a[31];
        neg_q = sgn & (a[31] ^ b[31]);
        ua    = neg_r ? -a : a;
        ub    = (sgn & b[31]) ? -b : b;
        if (ub == 32'd0) ub = 32'd1;
        uq    = ua / ub;
        ur    = ua % ub;
        return {(neg_r ? -ur : ur), (neg_q ? -uq : uq)};
    endfunction

    assign accept = Start && !Flush && (state == S_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            Busy       <= 1'b0;
            cnt        <= 4'd0;
            res_vld_p1 <= 1'b0;
            HI         <= 32'd0;
            LO         <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (Op)
                            OP_MULT, OP_MULTU: begin
                                res_p1     <= mul64(A, B, Op == OP_MULT);
                                res_vld_p1 <= 1'b1;
                                cnt        <= 4'(MULT_CYCLES);
                                Busy       <= 1'b1;
                                state      <= S_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                res_p1     <= div_qr(A, B, Op == OP_DIV);
                                res_vld_p1 <= (B != 32'd0);
                                cnt        <= 4'(DIV_CYCLES);
                                Busy       <= 1'b1;
                                state      <= S_BUSY;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // Stage boundary: result register -> architectural HI/LO
                    if (cnt == 4'd1) begin
                        cnt        <= 4'd0;
                        Busy       <= 1'b0;
                        state      <= S_IDLE;
                        res_vld_p1 <= 1'b0;
                        if (res_vld_p1) begin
                            HI <= res_p1[63:32];
                            LO <= res_p1[31:0];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
